pc_fetch_sequencer: RTL and testbench

//   Sequences the program-counter increment datapath against an instruction-fetch port.

---
 rtl/pc_fetch_sequencer_pkg.sv | 25 ++
 rtl/pc_fetch_sequencer_step_adder.sv | 21 ++
 rtl/pc_fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC fetch sequencer: state encodings and the
// default widths used by the RTL and by its bench.
package pc_fetch_sequencer_pkg;

   // Two-bit state encodings kept as plain constants for legacy tools.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_FETCH   = 2'd1;
   localparam logic [1:0] ST_ADVANCE = 2'd2;
   localparam logic [1:0] ST_FAULT   = 2'd3;

   // Default configuration.
   localparam int PC_WIDTH_DEF = 5;
   localparam int STEP_DEF     = 1;
   localparam int RESET_PC_DEF = 0;
   localparam int MAX_WAIT_DEF = 15;

   // Wide enough for the largest allowed MAX_WAIT (255).
   localparam int WAIT_W = 8;

   // True in the states where the sequencer is actively working.
   function automatic logic is_running(input logic [1:0] st);
      return (st == ST_FETCH) || (st == ST_ADVANCE);
   endfunction

endpackage

// File: rtl/pc_fetch_sequencer_step_adder.sv
// pc_step_adder: combinational PC increment by a fixed STEP, exposing the
// truncated sum and the carry out of the top PC bit.
module pc_step_adder #(
   parameter int PC_WIDTH = 5,
   parameter int STEP     = 1
) (
   input  logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] sum,
   output logic                carry_out
);

   // STEP is truncated to the PC width before it is added.
   localparam logic [PC_WIDTH-1:0] STEP_T = PC_WIDTH'(STEP);

   logic [PC_WIDTH:0] full_sum;

   assign full_sum  = {1'b0, pc} + {1'b0, STEP_T};
   assign sum       = full_sum[PC_WIDTH-1:0];
   assign carry_out = full_sum[PC_WIDTH];

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: holds the program counter, runs the req/ack fetch
// handshake, advances the PC by STEP or loads a branch target, and flags
// fetch timeouts and PC wrap.
// Optional feature macro: PC_WRAP_TRAP_EN -- when defined, an increment
// carry-out in ADVANCE sends the sequencer to FAULT (the PC still wraps and
// pc_wrap still pulses). Branch loads never trap.
module pc_fetch_sequencer
   import pc_fetch_sequencer_pkg::*;
#(
   parameter int PC_WIDTH = PC_WIDTH_DEF,
   parameter int STEP     = STEP_DEF,
   parameter int RESET_PC = RESET_PC_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                halt,
   input  logic                clear,
   input  logic                fetch_ack,
   input  logic                branch_valid,
   input  logic [PC_WIDTH-1:0] branch_target,
   output logic                fetch_req,
   output logic [PC_WIDTH-1:0] fetch_addr,
   output logic [PC_WIDTH-1:0] pc,
   output logic                running,
   output logic                fault,
   output logic                pc_wrap
);

`ifdef PC_WRAP_TRAP_EN
   localparam logic WRAP_TRAP = 1'b1;
`else
   localparam logic WRAP_TRAP = 1'b0;
`endif

   logic [1:0]        state;
   logic [1:0]        next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              halt_pending;
   logic [PC_WIDTH-1:0] inc_sum;
   logic              inc_carry;
   logic              wrap_event;

   pc_step_adder #(
      .PC_WIDTH (PC_WIDTH),
      .STEP     (STEP)
   ) u_step_adder (
      .pc        (pc),
      .sum       (inc_sum),
      .carry_out (inc_carry)
   );

   // The fetch port always sees the current PC.
   assign fetch_addr = pc;

   // A wrap only counts for a sequential increment, never for a branch load.
   assign wrap_event = (state == ST_ADVANCE) && !branch_valid && inc_carry;

   // Next-state decision; an ack in the timeout cycle takes priority over FAULT.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (start) next_state = ST_FETCH;
         end
         ST_FETCH: begin
            if (fetch_ack)                            next_state = ST_ADVANCE;
            else if (wait_cnt == WAIT_W'(MAX_WAIT))   next_state = ST_FAULT;
         end
         ST_ADVANCE: begin
            if (wrap_event && WRAP_TRAP)      next_state = ST_FAULT;
            else if (halt_pending || halt)    next_state = ST_IDLE;
            else                              next_state = ST_FETCH;
         end
         ST_FAULT: begin
            if (clear) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // State register plus the status outputs registered from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         fetch_req <= 1'b0;
         running   <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= next_state;
         fetch_req <= (next_state == ST_FETCH);
         running   <= is_running(next_state);
         fault     <= (next_state == ST_FAULT);
      end
   end

   // PC update happens only in ADVANCE; pc_wrap pulses alongside the new PC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= PC_WIDTH'(RESET_PC);
         pc_wrap <= 1'b0;
      end else begin
         pc_wrap <= wrap_event;
         if (state == ST_ADVANCE) begin
            pc <= branch_valid ? branch_target : inc_sum;
         end
      end
   end

   // Counts unacknowledged FETCH cycles; zero whenever FETCH is left or not active.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if ((state == ST_FETCH) && (next_state == ST_FETCH)) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   // Remembers a halt seen while working so the in-flight fetch can finish first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         halt_pending <= 1'b0;
      end else if ((next_state == ST_IDLE) && (state != ST_IDLE)) begin
         halt_pending <= 1'b0;
      end else if (is_running(state) && halt) begin
         halt_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed vector table,
// hand-written corner sequences, and randomized traffic against a
// behavioural model. Honours PC_WRAP_TRAP_EN when it is defined.
module tb_pc_fetch_sequencer;
   import pc_fetch_sequencer_pkg::*;

`ifdef PC_WRAP_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam int PW    = PC_WIDTH_DEF;
   localparam int PMOD  = 1 << PW;
   localparam int STEPV = STEP_DEF;
   localparam int MAXW  = MAX_WAIT_DEF;
   localparam bit H = 1'b1;
   localparam bit L = 1'b0;

   logic          clk;
   logic          reset;
   logic          start, halt, clear, fetch_ack, branch_valid;
   logic [PW-1:0] branch_target;
   logic          fetch_req, running, fault, pc_wrap;
   logic [PW-1:0] fetch_addr, pc;

   int total = 0;
   int bad   = 0;

   pc_fetch_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .halt          (halt),
      .clear         (clear),
      .fetch_ack     (fetch_ack),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .fetch_req     (fetch_req),
      .fetch_addr    (fetch_addr),
      .pc            (pc),
      .running       (running),
      .fault         (fault),
      .pc_wrap       (pc_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   // Activity flags rather than an encoded state: waiting on a fetch,
   // doing the one-cycle PC update, or stopped on a fault.
   int m_pc;
   bit m_fetching, m_updating, m_faulted, m_halt_req, m_wrap;
   int m_waited;

   task automatic model_reset();
      m_pc = RESET_PC_DEF; m_fetching = 0; m_updating = 0; m_faulted = 0;
      m_halt_req = 0; m_wrap = 0; m_waited = 0;
   endtask

   task automatic model_step(input bit st, input bit hl, input bit cl, input bit ak,
                             input bit bv, input int bt);
      int nxt;
      bit carried;
      carried = 0;
      m_wrap  = 0;
      if (m_faulted) begin
         if (cl) begin m_faulted = 0; m_halt_req = 0; m_waited = 0; end
      end else if (m_fetching) begin
         if (hl) m_halt_req = 1;
         if (ak) begin
            m_fetching = 0; m_updating = 1; m_waited = 0;
         end else if (m_waited >= MAXW) begin
            m_fetching = 0; m_faulted = 1; m_waited = 0;
         end else begin
            m_waited++;
         end
      end else if (m_updating) begin
         m_updating = 0;
         if (bv) begin
            m_pc = bt;
         end else begin
            nxt     = m_pc + (STEPV % PMOD);
            carried = (nxt >= PMOD);
            m_pc    = nxt % PMOD;
            m_wrap  = carried;
         end
         if (carried && TRAP) begin
            m_faulted = 1;
            if (hl) m_halt_req = 1;
         end else if (m_halt_req || hl) begin
            m_halt_req = 0;
         end else begin
            m_fetching = 1;
         end
      end else if (st) begin
         m_fetching = 1; m_waited = 0;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic compare_model();
      chk("model_pc",         32'(pc),         32'(m_pc));
      chk("model_fetch_addr", 32'(fetch_addr), 32'(m_pc));
      chk("model_fetch_req",  32'(fetch_req),  32'(m_fetching));
      chk("model_running",    32'(running),    32'(m_fetching | m_updating));
      chk("model_fault",      32'(fault),      32'(m_faulted));
      chk("model_pc_wrap",    32'(pc_wrap),    32'(m_wrap));
   endtask

   // One clock: drive at the falling edge, check after the next falling edge.
   task automatic step(input bit st, input bit hl, input bit cl, input bit ak,
                       input bit bv, input logic [PW-1:0] bt);
      start = st; halt = hl; clear = cl; fetch_ack = ak;
      branch_valid = bv; branch_target = bt;
      model_step(st, hl, cl, ak, bv, int'(bt));
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   typedef struct {
      bit st, hl, cl, ak, bv;
      logic [PW-1:0] bt;
      logic [PW-1:0] e_pc;
      bit e_req, e_run, e_fault, e_wrap;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int ack_pct;
      // Sequential fetches with ack one cycle after req, then branch handling.
      tbl[0]  = '{H,L,L,L,L,5'h00, 5'h00, H,H,L,L};
      tbl[1]  = '{L,L,L,L,L,5'h00, 5'h00, H,H,L,L};
      tbl[2]  = '{L,L,L,H,L,5'h00, 5'h00, L,H,L,L};
      tbl[3]  = '{L,L,L,L,L,5'h00, 5'h01, H,H,L,L};
      tbl[4]  = '{L,L,L,L,L,5'h00, 5'h01, H,H,L,L};
      tbl[5]  = '{L,L,L,H,L,5'h00, 5'h01, L,H,L,L};
      tbl[6]  = '{L,L,L,L,L,5'h00, 5'h02, H,H,L,L};
      tbl[7]  = '{L,L,L,L,L,5'h00, 5'h02, H,H,L,L};
      tbl[8]  = '{L,L,L,H,L,5'h00, 5'h02, L,H,L,L};
      tbl[9]  = '{L,L,L,L,L,5'h00, 5'h03, H,H,L,L};
      tbl[10] = '{H,L,H,L,H,5'h03, 5'h03, H,H,L,L};
      tbl[11] = '{L,L,L,H,L,5'h00, 5'h03, L,H,L,L};
      tbl[12] = '{L,L,L,L,H,5'h12, 5'h12, H,H,L,L};
      tbl[13] = '{L,L,L,L,L,5'h00, 5'h12, H,H,L,L};
      tbl[14] = '{L,L,L,H,L,5'h00, 5'h12, L,H,L,L};
      tbl[15] = '{L,L,L,L,L,5'h00, 5'h13, H,H,L,L};

      reset = 1'b0; start = 0; halt = 0; clear = 0; fetch_ack = 0;
      branch_valid = 0; branch_target = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_pc",        32'(pc),        32'h0);
      chk("reset_fetch_req", 32'(fetch_req), 32'h0);
      chk("reset_running",   32'(running),   32'h0);
      chk("reset_fault",     32'(fault),     32'h0);
      chk("reset_pc_wrap",   32'(pc_wrap),   32'h0);
      reset = 1'b1;

      // Directed vector table.
      for (int i = 0; i < 16; i++) begin
         step(tbl[i].st, tbl[i].hl, tbl[i].cl, tbl[i].ak, tbl[i].bv, tbl[i].bt);
         chk($sformatf("vec%0d_pc", i),      32'(pc),        32'(tbl[i].e_pc));
         chk($sformatf("vec%0d_addr", i),    32'(fetch_addr),32'(tbl[i].e_pc));
         chk($sformatf("vec%0d_req", i),     32'(fetch_req), 32'(tbl[i].e_req));
         chk($sformatf("vec%0d_running", i), 32'(running),   32'(tbl[i].e_run));
         chk($sformatf("vec%0d_fault", i),   32'(fault),     32'(tbl[i].e_fault));
         chk($sformatf("vec%0d_wrap", i),    32'(pc_wrap),   32'(tbl[i].e_wrap));
      end

      // Fetch timeout: 16 unacknowledged FETCH cycles reach FAULT.
      for (int i = 0; i < MAXW; i++) step(L,L,L,L,L,5'h00);
      chk("timeout_early_fault", 32'(fault), 32'h0);
      step(L,L,L,L,L,5'h00);
      chk("timeout_fault",     32'(fault),     32'h1);
      chk("timeout_fetch_req", 32'(fetch_req), 32'h0);
      step(L,L,L,L,L,5'h00);
      chk("fault_pc_hold", 32'(pc), 32'h13);
      step(L,L,H,L,L,5'h00);
      chk("clear_pc",      32'(pc),      32'h13);
      chk("clear_fault",   32'(fault),   32'h0);
      chk("clear_running", 32'(running), 32'h0);

      // Ack in the timeout cycle wins over the fault.
      step(H,L,L,L,L,5'h00);
      for (int i = 0; i < MAXW; i++) step(L,L,L,L,L,5'h00);
      step(L,L,L,H,L,5'h00);
      chk("late_ack_fault",   32'(fault),     32'h0);
      chk("late_ack_running", 32'(running),   32'h1);
      chk("late_ack_req",     32'(fetch_req), 32'h0);
      step(L,L,L,L,L,5'h00);
      chk("late_ack_pc", 32'(pc), 32'h14);

      // Halt mid-FETCH: fetch completes, PC advances once, then IDLE.
      step(L,H,L,L,L,5'h00);
      chk("halt_req_held", 32'(fetch_req), 32'h1);
      step(L,L,L,L,L,5'h00);
      step(L,L,L,L,L,5'h00);
      step(L,L,L,H,L,5'h00);
      step(L,L,L,L,L,5'h00);
      chk("halt_pc",      32'(pc),        32'h15);
      chk("halt_req",     32'(fetch_req), 32'h0);
      chk("halt_running", 32'(running),   32'h0);
      step(L,L,L,L,L,5'h00);
      chk("halt_stays_idle", 32'(fetch_req), 32'h0);
      step(H,L,L,L,L,5'h00);
      chk("resume_addr", 32'(fetch_addr), 32'h15);
      chk("resume_req",  32'(fetch_req),  32'h1);

      // PC wrap from 5'h1F.
      step(L,L,L,H,L,5'h00);
      step(L,L,L,L,H,5'h1F);
      chk("branch_1f_pc", 32'(pc), 32'h1F);
      step(L,L,L,H,L,5'h00);
      step(L,L,L,L,L,5'h00);
      chk("wrap_pc",    32'(pc),      32'h0);
      chk("wrap_pulse", 32'(pc_wrap), 32'h1);
      chk("wrap_fault", 32'(fault),   TRAP ? 32'h1 : 32'h0);
      chk("wrap_req",   32'(fetch_req), TRAP ? 32'h0 : 32'h1);
      if (TRAP) step(L,L,H,L,L,5'h00);
      else      step(L,L,L,L,L,5'h00);
      chk("wrap_pulse_end", 32'(pc_wrap), 32'h0);

      // Asynchronous reset while in FETCH.
      if (m_faulted) step(L,L,H,L,L,5'h00);
      if (!m_fetching && !m_updating) step(H,L,L,L,L,5'h00);
      step(L,L,L,H,L,5'h00);
      step(L,L,L,L,L,5'h00);
      chk("pre_reset_pc",  32'(pc),        32'h1);
      chk("pre_reset_req", 32'(fetch_req), 32'h1);
      #2 reset = 1'b0;
      #1;
      model_reset();
      chk("async_reset_pc",      32'(pc),        32'h0);
      chk("async_reset_req",     32'(fetch_req), 32'h0);
      chk("async_reset_running", 32'(running),   32'h0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step(L,L,L,L,L,5'h00);
      chk("post_reset_idle", 32'(running), 32'h0);

      // Randomized traffic against the model.
      ack_pct = 40;
      for (int i = 0; i < 3000; i++) begin
         if (i % 300 == 0) ack_pct = (($urandom_range(0, 2) == 0) ? 4 : (($urandom_range(0, 1) == 0) ? 40 : 85));
         step(bit'($urandom_range(0, 99) < 30),
              bit'($urandom_range(0, 99) < 5),
              bit'($urandom_range(0, 99) < 30),
              bit'($urandom_range(0, 99) < ack_pct),
              bit'($urandom_range(0, 99) < 30),
              PW'($urandom_range(0, PMOD - 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
